// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity generator/checker pair:
// receive FSM states and the parity rule both ends agree on.
package parity_pkg;

  localparam int MAX_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    DRAIN
  } state_t;

  // Narrower words are zero-extended, which leaves the XOR-reduce unchanged.
  function automatic logic expected_parity(input logic [MAX_BITS-1:0] word, input logic even);
    return (^word) ^ even;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/serial_parity_checker.sv
// Receive-side serial deserializer: collects NUM_BITS data bits MSB first plus one
// parity bit, reports the word with its parity result, and flags framing violations.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int NUM_BITS        = 4,
  parameter bit EVEN_PARITY_BIT = 1'b1,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_in,
  input  logic                     wr_en,
  input  logic                     clear_cnt,
  output logic [NUM_BITS-1:0]      word_out,
  output logic                     word_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int CNT_W = $clog2(NUM_BITS);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [NUM_BITS-1:0] shift_reg, shift_next;
  logic [NUM_BITS-1:0] word_reg, word_next;
  logic                word_valid_reg, word_valid_next;
  logic                parity_err_reg, parity_err_next;
  logic                frame_err_reg, frame_err_next;
  logic                overrun_reg, overrun_next;
  logic [NUM_BITS-1:0] shift_in;
  logic                err_event;

  assign shift_in = {shift_reg[NUM_BITS-2:0], data_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      word_reg       <= word_next;
      word_valid_reg <= word_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    word_next       = word_reg;
    word_valid_next = 1'b0;
    parity_err_next = parity_err_reg;
    frame_err_next  = 1'b0;
    overrun_next    = overrun_reg;

    case (state_reg)
      IDLE: begin
        if (wr_en) begin
          shift_next = shift_in;
          cnt_next   = CNT_W'(1);
          state_next = DATA;
        end
      end
      DATA: begin
        if (wr_en) begin
          shift_next = shift_in;
          if (cnt_reg == CNT_W'(NUM_BITS - 1)) begin
            cnt_next   = '0;
            state_next = PARITY;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          frame_err_next = 1'b1;
          cnt_next       = '0;
          state_next     = IDLE;
        end
      end
      PARITY: begin
        if (wr_en) begin
          word_valid_next = 1'b1;
          word_next       = shift_reg;
          parity_err_next = data_in != expected_parity(MAX_BITS'(shift_reg), EVEN_PARITY_BIT);
          overrun_next    = 1'b0;
          state_next      = DRAIN;
        end else begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end
      DRAIN: begin
        // An overrun is reported once however long wr_en lingers.
        if (wr_en) begin
          frame_err_next = !overrun_reg;
          overrun_next   = 1'b1;
        end else begin
          overrun_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign err_event = (word_valid_reg & parity_err_reg) | frame_err_reg;

  sat_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_event),
    .clr  (clear_cnt),
    .count(err_count)
  );

  assign word_out   = word_reg;
  assign word_valid = word_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: two checkers (8-bit and 2-bit error counters) share one serial
// stimulus stream; a frame-level reference model predicts every output pulse.
module tb_serial_parity_checker;

  localparam int N    = 4;
  localparam bit EVEN = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in = 1'b0;
  logic wr_en = 1'b0;
  logic clear_cnt = 1'b0;

  logic [N-1:0] word_out8, word_out2;
  logic         wv8, wv2, perr8, perr2, fe8, fe2;
  logic [7:0]   cnt8;
  logic [1:0]   cnt2;

  serial_parity_checker #(.NUM_BITS(N), .EVEN_PARITY_BIT(EVEN), .ERR_CNT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .clear_cnt(clear_cnt),
    .word_out(word_out8), .word_valid(wv8), .parity_err(perr8), .frame_err(fe8),
    .err_count(cnt8)
  );

  serial_parity_checker #(.NUM_BITS(N), .EVEN_PARITY_BIT(EVEN), .ERR_CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .clear_cnt(clear_cnt),
    .word_out(word_out2), .word_valid(wv2), .parity_err(perr2), .frame_err(fe2),
    .err_count(cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_ferr;
    logic [N-1:0] word;
    logic         perr;
    int           cnt8;
    int           cnt2;
    int           at;
  } ev_t;

  ev_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: last reported word/parity and the two error counts.
  logic [N-1:0] m_word = '0;
  logic         m_perr = 1'b0;
  int           m_cnt8 = 0;
  int           m_cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_ferr, input bit clr);
    ev_t e;
    if (is_ferr || m_perr) begin
      m_cnt8 = (m_cnt8 >= 255) ? 255 : m_cnt8 + 1;
      m_cnt2 = (m_cnt2 >= 3) ? 3 : m_cnt2 + 1;
    end
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
    e.is_ferr = is_ferr;
    e.word    = m_word;
    e.perr    = m_perr;
    e.cnt8    = m_cnt8;
    e.cnt2    = m_cnt2;
    e.at      = cyc + 1;
    sb.push_back(e);
  endtask

  function automatic logic [39:0] mk(input logic [N-1:0] w, input logic p);
    logic [39:0] r;
    for (int i = 0; i < 40; i++) r[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) r[i] = w[N-1-i];
    r[N] = p;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en     = 1'b0;
      clear_cnt = 1'b0;
    end
  endtask

  // Holds wr_en for len cycles sending bits[0..len-1], then gap idle cycles.
  // clr raises clear_cnt in the first gap cycle, coinciding with the word's count update.
  task automatic send(input int len, input logic [39:0] bits, input int gap, input bit clr);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      wr_en     = 1'b1;
      data_in   = bits[i];
      clear_cnt = 1'b0;
      if (i == N) begin
        int w;
        int ones;
        w = 0;
        ones = 0;
        for (int j = 0; j < N; j++) begin
          w    = w * 2 + int'(bits[j]);
          ones = ones + int'(bits[j]);
        end
        m_word = w[N-1:0];
        m_perr = bits[N] ^ (((ones % 2) == 1) ^ EVEN);
        push(1'b0, clr);
      end
      if (i == N + 1) push(1'b1, 1'b0);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      wr_en     = 1'b0;
      data_in   = 1'($urandom_range(0, 1));
      clear_cnt = (g == 0) && clr;
      if (g == 0 && len <= N) push(1'b1, 1'b0);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    wr_en     = 1'b0;
    clear_cnt = 1'b1;
    m_cnt8    = 0;
    m_cnt2    = 0;
    @(negedge clk);
    clear_cnt = 1'b0;
    chk("clear_cnt8", 32'(cnt8), 0);
    chk("clear_cnt2", 32'(cnt2), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word_out"}, 32'(word_out8), 0);
    chk({tag, "_word_valid"}, 32'(wv8), 0);
    chk({tag, "_parity_err"}, 32'(perr8), 0);
    chk({tag, "_frame_err"}, 32'(fe8), 0);
    chk({tag, "_err_count8"}, 32'(cnt8), 0);
    chk({tag, "_err_count2"}, 32'(cnt2), 0);
  endtask

  // Monitor: every output pulse pops one predicted event; the count is checked a cycle later.
  initial begin
    ev_t e;
    bit  pend;
    int  p8, p2;
    pend = 1'b0;
    p8 = 0;
    p2 = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("err_count8", 32'(cnt8), 32'(p8));
        chk("err_count2", 32'(cnt2), 32'(p2));
        pend = 1'b0;
      end
      if (rst_n && (wv8 || fe8)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: word_valid=%0b frame_err=%0b at cycle %0d, expected no pulse",
                   wv8, fe8, cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(e.at));
          chk("word_valid", 32'(wv8), 32'(!e.is_ferr));
          chk("frame_err", 32'(fe8), 32'(e.is_ferr));
          chk("word_out", 32'(word_out8), 32'(e.word));
          chk("parity_err", 32'(perr8), 32'(e.perr));
          chk("word_out_w2", 32'(word_out2), 32'(e.word));
          p8   = e.cnt8;
          p2   = e.cnt2;
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Good frame, then a parity error, then a frame cut short after two bits.
    send(N + 1, mk(4'b1001, 1'b1), 1, 1'b0);
    idle(3);
    send(N + 1, mk(4'b1101, 1'b1), 1, 1'b0);
    idle(3);
    send(2, mk(4'b1011, 1'b0), 1, 1'b0);
    idle(3);

    // Overrun: wr_en held seven cycles, then a frame after a one-cycle gap.
    send(7, mk(4'b0110, 1'b1), 1, 1'b0);
    send(N + 1, mk(4'b0011, 1'b0), 1, 1'b0);
    idle(3);

    // Saturation of the 2-bit counter, then clear colliding with an increment.
    repeat (5) send(N + 1, mk(4'b1000, 1'b1), 1, 1'b0);
    idle(3);
    chk("saturated_cnt2", 32'(cnt2), 3);
    send(N + 1, mk(4'b1000, 1'b1), 1, 1'b1);
    idle(3);
    chk("clear_priority8", 32'(cnt8), 0);
    chk("clear_priority2", 32'(cnt2), 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      data_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    m_word = '0;
    m_perr = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midframe_reset");
    rst_n = 1'b1;
    idle(3);
    send(N + 1, mk(4'b1010, 1'b1), 1, 1'b0);
    idle(3);

    // Randomized frames: mostly well-formed, some short, some overrun.
    for (int k = 0; k < 150; k++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 9));
      if (r < 2)       len = int'($urandom_range(1, N));
      else if (r == 2) len = int'($urandom_range(N + 2, N + 4));
      else             len = N + 1;
      send(len, mk(N'($urandom), 1'($urandom_range(0, 1))), int'($urandom_range(1, 3)), 1'b0);
      if (k % 30 == 29) do_clear();
    end

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
